// File: rtl/autocorr_accumulator_if.sv
// Handshake bundle between the word source, the autocorrelation
// accumulator and the result consumer. Peak outputs need AUTOCORR_PEAK_EN.
interface autocorr_accumulator_if #(
    parameter int WIDTH  = 3,
    parameter int LAGS   = 4,
    parameter int WINDOW = 64,
    parameter int ACC_W  = $clog2(WINDOW*WIDTH+1)+1
);
    localparam int LAG_W = $clog2(LAGS);

    logic                    start;
    logic [WIDTH-1:0]        in_word;
    logic                    in_strobe;
    logic                    res_valid;
    logic                    res_ready;
    logic [LAG_W-1:0]        res_lag;
    logic signed [ACC_W-1:0] res_data;
    logic                    busy;
    logic                    done;
    logic                    overrun;
`ifdef AUTOCORR_PEAK_EN
    logic [LAG_W-1:0]        peak_lag;
    logic signed [ACC_W-1:0] peak_val;

    modport master (
        output start, in_word, in_strobe, res_ready,
        input  res_valid, res_lag, res_data, busy, done, overrun,
        input  peak_lag, peak_val
    );
    modport slave (
        input  start, in_word, in_strobe, res_ready,
        output res_valid, res_lag, res_data, busy, done, overrun,
        output peak_lag, peak_val
    );
`else
    modport master (
        output start, in_word, in_strobe, res_ready,
        input  res_valid, res_lag, res_data, busy, done, overrun
    );
    modport slave (
        input  start, in_word, in_strobe, res_ready,
        output res_valid, res_lag, res_data, busy, done, overrun
    );
`endif
endinterface

// File: rtl/autocorr_accumulator.sv
// Per-lag signed match-score accumulator over a window of strobed words,
// results unloaded one lag per handshake. AUTOCORR_PEAK_EN adds peak tracking.
module autocorr_accumulator #(
    parameter int WIDTH  = 3,
    parameter int LAGS   = 4,
    parameter int WINDOW = 64,
    parameter int ACC_W  = $clog2(WINDOW*WIDTH+1)+1
) (
    input logic                  clk,
    input logic                  rst,
    autocorr_accumulator_if.slave bus
);
    localparam int LAG_W = $clog2(LAGS);
    localparam int CNT_W = $clog2(WINDOW+1);

    typedef enum logic [1:0] {IDLE, ACCUM, DUMP} state_t;

    state_t                  state;
    state_t                  state_next;
    logic [CNT_W-1:0]        n;
    logic [LAG_W-1:0]        lag;
    logic                    done_q;
    logic                    overrun_q;
    logic [WIDTH-1:0]        hist [LAGS-1];
    logic [WIDTH-1:0]        tap [LAGS];
    logic [ACC_W-1:0]        score [LAGS];
    logic signed [ACC_W-1:0] acc [LAGS];
    logic                    take;
    logic                    last;
    logic                    accept;
    logic                    last_accept;
    logic                    run_start;

    assign run_start = (state == IDLE) && bus.start;

    // Match score per lag: +1 per agreeing bit, -1 per differing bit.
    always_comb begin
        tap[0] = bus.in_word;
        for (int k = 1; k < LAGS; k++) tap[k] = hist[k-1];
        for (int k = 0; k < LAGS; k++) begin
            score[k] = ACC_W'(WIDTH)
                     - ACC_W'(2 * $countones(bus.in_word ^ tap[k]));
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and per-cycle control strobes.
    always_comb begin
        state_next  = state;
        take        = 1'b0;
        last        = 1'b0;
        accept      = 1'b0;
        last_accept = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) state_next = ACCUM;
            end
            ACCUM: begin
                take = bus.in_strobe;
                last = take && (n == CNT_W'(WINDOW-1));
                if (last) state_next = DUMP;
            end
            DUMP: begin
                accept      = bus.res_ready;
                last_accept = accept && (lag == LAG_W'(LAGS-1));
                if (last_accept) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Accumulators, history, sample count, result index and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n         <= '0;
            lag       <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            for (int k = 0; k < LAGS; k++)   acc[k]  <= '0;
            for (int j = 0; j < LAGS-1; j++) hist[j] <= '0;
        end else begin
            done_q <= last_accept;
            if (run_start) begin
                n         <= '0;
                lag       <= '0;
                overrun_q <= 1'b0;
                for (int k = 0; k < LAGS; k++)   acc[k]  <= '0;
                for (int j = 0; j < LAGS-1; j++) hist[j] <= '0;
            end else if (state != ACCUM && bus.in_strobe) begin
                overrun_q <= 1'b1;
            end
            if (take) begin
                // Lag k only has a partner once k earlier words exist.
                for (int k = 0; k < LAGS; k++) begin
                    if (k == 0 || int'(n) >= k) acc[k] <= acc[k] + score[k];
                end
                hist[0] <= bus.in_word;
                for (int j = 1; j < LAGS-1; j++) hist[j] <= hist[j-1];
                n <= n + CNT_W'(1);
            end
            if (accept) lag <= last_accept ? '0 : lag + LAG_W'(1);
        end
    end

    assign bus.res_valid = (state == DUMP);
    assign bus.res_lag   = bus.res_valid ? lag : '0;
    assign bus.res_data  = bus.res_valid ? acc[lag] : '0;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.overrun   = overrun_q;

`ifdef AUTOCORR_PEAK_EN
    logic [LAG_W-1:0]        peak_lag_q;
    logic signed [ACC_W-1:0] peak_val_q;

    // Best lag >= 1 seen while unloading; ties keep the lower lag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peak_lag_q <= '0;
            peak_val_q <= '0;
        end else if (run_start) begin
            peak_lag_q <= '0;
            peak_val_q <= '0;
        end else if (accept && lag != '0 && acc[lag] > peak_val_q) begin
            peak_lag_q <= lag;
            peak_val_q <= acc[lag];
        end
    end

    assign bus.peak_lag = peak_lag_q;
    assign bus.peak_val = peak_val_q;
`endif
endmodule

// File: doc/autocorr_accumulator.md
Name: autocorr_accumulator

Overview:
- Downstream consumer of the serial-to-parallel shift register stage on the DE1-SoC autocorrelation path.
- Takes each WIDTH-bit word plus its one-cycle strobe and keeps a history of the last LAGS-1 words.
- Accumulates a signed match score per lag over a window of WINDOW words, then unloads the LAGS results one per handshake.

Parameters:
- WIDTH, 3, bits per input word; matches the upstream word width.
- LAGS, 4, number of lags computed (0..LAGS-1); must be >= 2.
- WINDOW, 64, number of strobed words accumulated per run; must be >= LAGS.
- ACC_W, $clog2(WINDOW*WIDTH+1)+1, signed accumulator and result width.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle run request; accepted only in IDLE.
- in_word  in  WIDTH  parallel word from the upstream stage.
- in_strobe  in  1  one-cycle pulse marking in_word as new.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_lag  out  $clog2(LAGS)  lag index of res_data.
- res_data  out  ACC_W  signed correlation sum for res_lag.
- busy  out  1  high in ACCUM and DUMP.
- done  out  1  one-cycle pulse after the last result is accepted.
- overrun  out  1  sticky flag: a strobe arrived outside ACCUM.

Behaviour:
- Reset: state is IDLE. All outputs are 0, and the accumulators, history, and sample counter are cleared. Reset mid-run aborts the run and no partial result is ever presented.
- FSM states are IDLE, ACCUM and DUMP.
- IDLE -> ACCUM on start. On that edge, clear the accumulators, history, sample counter n, and overrun. A strobe in the same cycle as start is ignored and does not set overrun.
- ACCUM, on each in_strobe with current sample x = in_word:
  - For each lag k: if k == 0 or k <= n, add s_k = WIDTH - 2*popcount(x XOR h[k]) to acc[k]. h[0] = x and h[k] is the word strobed k samples earlier. Otherwise add nothing, so lag k receives WINDOW-k terms.
  - Shift x into the history and increment n.
  - s_k ranges -WIDTH..+WIDTH and is sign-extended to ACC_W. No overflow is possible with the default ACC_W.
  - Accumulators update on the edge that samples the strobe. Strobes may arrive back-to-back on consecutive cycles.
- ACCUM -> DUMP on the edge that accumulates the WINDOW-th strobe. res_valid rises on that same edge, with res_lag = 0.
- DUMP:
  - res_data = acc[res_lag].
  - res_valid, res_lag and res_data are held stable while res_ready is low.
  - When res_valid & res_ready, advance res_lag. After lag LAGS-1 is accepted: res_valid goes to 0, done pulses for one cycle, and the state goes to IDLE.
  - res_valid is never deasserted without a handshake.
- In DUMP or IDLE, in_strobe is ignored (no accumulation) and sets overrun. overrun stays set until the next accepted start or reset.
- start in ACCUM or DUMP is ignored.
- res_data and res_lag read 0 when res_valid is 0.

Optional Feature:
Macro name: AUTOCORR_PEAK_EN.
- Defined:
  - Adds outputs peak_lag [$clog2(LAGS)] and peak_val [ACC_W] (signed).
  - Both are cleared on start and updated during DUMP as each lag k >= 1 is accepted. Lag 0 is excluded.
  - The update is strictly greater-than, so ties keep the lower lag.
  - Both are final and stable from the done pulse until the next start.
- Undefined: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- Defaults; start, then 64 strobes of 3'b101, then res_ready held high -> results lag0 = +192, lag1 = +189, lag2 = +186, lag3 = +183; done pulses once; busy = 0 afterwards.
- Alternating 3'b000 / 3'b111 for 64 strobes -> lag0 = +192, lag1 = -189, lag2 = +186, lag3 = -183. With AUTOCORR_PEAK_EN: peak_lag = 2, peak_val = +186.
- Backpressure: hold res_ready low for 5 cycles while res_lag = 1 -> res_valid stays 1 and res_data stays +189 unchanged; the next accepted result is lag 2.
- Strobes during DUMP and during IDLE -> overrun = 1 and results are unchanged. The next start clears overrun to 0.
- Assert rst after 10 strobes in ACCUM -> immediately busy = 0 and res_valid = 0. A fresh run with constant 3'b101 gives lag0 = +192.
- start pulses in ACCUM and in DUMP -> ignored; the run completes with correct values. start and in_strobe in the same cycle in IDLE -> that strobe is not counted (64 further strobes are needed).
